mdu_seq: RTL and testbench

Iterative multiply/divide unit with HI/LO registers, parametrised in operand width; the next-generation execute-stage companion to the ALU in the MIPS datapath. It performs MULT/MULTU/DIV/DIVU over multiple cycles with a Start/Busy handshake, and supports single-cycle MTHI/MTLO. HI and LO are held for MFHI/MFLO. The controller stalls issue of MDU instructions while Busy is high.

---
 rtl/mdu_seq_pkg.sv | 31 +++
 rtl/mdu_iter.sv | 62 ++++++
 rtl/mdu_seq.sv | 130 +++++++++++++
 tb/tb_mdu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared MDU opcode and FSM state encodings, plus opcode classification helpers
// used by the multiply/divide unit and the issuing controller.
package mdu_seq_pkg;

   localparam logic [2:0] MDU_NONE  = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iteration datapath shared by radix-2 shift-add multiply and restoring divide:
// one WIDTH+1-bit add/subtract, a 2*WIDTH-bit shift register and a step counter.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc_hi,
   output logic [WIDTH-1:0] acc_lo,
   output logic             last
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_reg;
   logic [WIDTH-1:0] lo_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH:0]   x;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   t;

   always_comb begin
      x   = is_div ? {hi_reg, lo_reg[WIDTH-1]} : {1'b0, hi_reg};
      sum = is_div ? (x - {1'b0, operand}) : (x + {1'b0, operand});
      t   = lo_reg[0] ? sum : x;
      if (is_div) begin
         // Partial remainder is always below the divisor, so the MSB of the difference is the borrow.
         hi_next = sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0];
         lo_next = {lo_reg[WIDTH-2:0], ~sum[WIDTH]};
      end else begin
         hi_next = t[WIDTH:1];
         lo_next = {t[0], lo_reg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hi_reg  <= '0;
         lo_reg  <= '0;
         cnt_reg <= '0;
      end else if (load) begin
         hi_reg  <= '0;
         lo_reg  <= load_val;
         cnt_reg <= '0;
      end else if (step) begin
         hi_reg  <= hi_next;
         lo_reg  <= lo_next;
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign acc_hi = hi_reg;
   assign acc_lo = lo_reg;
   assign last   = (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit with HI/LO registers: Start/Busy handshake,
// WIDTH+1 busy cycles per MULT/DIV, single-cycle MTHI/MTLO.
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       MDUop,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   state_t             state_reg;
   state_t             state_next;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               done_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2:0]         op_reg;

   logic               accept_arith;
   logic               iter_load;
   logic               iter_step;
   logic               op_signed;
   logic               op_div;
   logic [WIDTH-1:0]   a_in_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   it_hi;
   logic [WIDTH-1:0]   it_lo;
   logic               it_last;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   hi_fix;
   logic [WIDTH-1:0]   lo_fix;

   assign accept_arith = (state_reg == S_IDLE) && Start && is_arith(MDUop);
   assign op_signed    = is_signed_op(op_reg);
   assign op_div       = is_div_op(op_reg);
   assign a_in_mag     = (is_signed_op(MDUop) && A[WIDTH-1]) ? -A : A;
   assign b_mag        = (op_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (Clk),
      .reset_n  (Reset),
      .load     (iter_load),
      .step     (iter_step),
      .is_div   (op_div),
      .load_val (a_in_mag),
      .operand  (b_mag),
      .acc_hi   (it_hi),
      .acc_lo   (it_lo),
      .last     (it_last)
   );

   always_ff @(posedge Clk) begin
      if (!Reset) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept_arith) state_next = S_RUN;
         S_RUN:   if (it_last) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      Busy      = (state_reg == S_RUN) || (state_reg == S_FIX);
      iter_load = accept_arith;
      iter_step = (state_reg == S_RUN);
   end

   // Sign fix-up applied to the unsigned magnitude result; most-negative / -1 falls out naturally.
   always_comb begin
      prod   = {it_hi, it_lo};
      hi_fix = it_hi;
      lo_fix = it_lo;
      if (!op_div) begin
         if (op_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) prod = -prod;
         hi_fix = prod[2*WIDTH-1:WIDTH];
         lo_fix = prod[WIDTH-1:0];
      end else if (b_reg == '0) begin
         hi_fix = a_reg;
         lo_fix = '1;
      end else begin
         if (op_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) lo_fix = -it_lo;
         if (op_signed && a_reg[WIDTH-1]) hi_fix = -it_hi;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         hi_reg   <= '0;
         lo_reg   <= '0;
         done_reg <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         op_reg   <= MDU_NONE;
      end else begin
         done_reg <= 1'b0;
         if (accept_arith) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= MDUop;
         end
         if (state_reg == S_FIX) begin
            hi_reg   <= hi_fix;
            lo_reg   <= lo_fix;
            done_reg <= 1'b1;
         end else if ((state_reg == S_IDLE) && Start) begin
            if (MDUop == MDU_MTHI) hi_reg <= A;
            if (MDUop == MDU_MTLO) lo_reg <= A;
         end
      end
   end

   assign Done = done_reg;
   assign HI   = hi_reg;
   assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (WIDTH=32): directed scenarios plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_mdu_seq;
   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [2:0]  MDUop;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mdu_seq #(.WIDTH(32)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .MDUop (MDUop),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .Done  (Done),
      .HI    (HI),
      .LO    (LO)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result as {HI, LO}, computed with wide signed/unsigned arithmetic.
   function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      longint unsigned ua;
      longint unsigned ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: return 64'(sa * sb);
         3'd2: return ua * ub;
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
         default: return {model_hi, model_lo};
      endcase
   endfunction

   // Issue MULT/DIV; optionally poke a second Start or pull Reset at busy cycle n.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int poke_at, input int reset_at);
      logic [63:0] exp;
      int n;
      bit stable;
      exp = ref_op(op, a, b);
      Start = 1'b1; MDUop = op; A = a; B = b;
      tick();
      Start = 1'b0; MDUop = 3'($urandom); A = $urandom; B = $urandom;
      chk({tag, "_busy_start"}, 64'(Busy), 64'd1);
      chk({tag, "_done_low"}, 64'(Done), 64'd0);
      n = 0;
      stable = 1'b1;
      while (Busy === 1'b1 && n < 40) begin
         if (HI !== model_hi || LO !== model_lo || Done !== 1'b0) stable = 1'b0;
         if (n == reset_at) begin
            Reset = 1'b0;
            tick();
            Reset = 1'b1;
            chk({tag, "_rst_busy"}, 64'(Busy), 64'd0);
            chk({tag, "_rst_done"}, 64'(Done), 64'd0);
            chk({tag, "_rst_hi"}, 64'(HI), 64'd0);
            chk({tag, "_rst_lo"}, 64'(LO), 64'd0);
            model_hi = '0;
            model_lo = '0;
            $display("op %s op=%0d a=%h b=%h aborted by reset", tag, op, a, b);
            return;
         end
         if (n == poke_at) begin
            Start = 1'b1; MDUop = 3'd2; A = 32'd2; B = 32'd2;
         end else begin
            Start = 1'b0;
         end
         n++;
         tick();
      end
      Start = 1'b0;
      chk({tag, "_hold_old"}, 64'(stable), 64'd1);
      chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
      chk({tag, "_done"}, 64'(Done), 64'd1);
      chk({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
      chk({tag, "_hi"}, 64'(HI), 64'(exp[63:32]));
      chk({tag, "_lo"}, 64'(LO), 64'(exp[31:0]));
      model_hi = exp[63:32];
      model_lo = exp[31:0];
      $display("op %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, HI, LO);
   endtask

   task automatic do_mt(input logic [2:0] op, input logic [31:0] v, input string tag);
      Start = 1'b1; MDUop = op; A = v; B = $urandom;
      tick();
      Start = 1'b0;
      if (op == 3'd5) model_hi = v;
      if (op == 3'd6) model_lo = v;
      chk({tag, "_hi"}, 64'(HI), 64'(model_hi));
      chk({tag, "_lo"}, 64'(LO), 64'(model_lo));
      chk({tag, "_busy"}, 64'(Busy), 64'd0);
      chk({tag, "_done"}, 64'(Done), 64'd0);
      $display("op %s op=%0d v=%h -> hi=%h lo=%h", tag, op, v, HI, LO);
   endtask

   task automatic do_nop(input logic [2:0] op, input string tag);
      Start = 1'b1; MDUop = op; A = $urandom; B = $urandom;
      tick();
      Start = 1'b0;
      chk({tag, "_busy"}, 64'(Busy), 64'd0);
      chk({tag, "_hilo"}, {HI, LO}, {model_hi, model_lo});
      $display("op %s op=%0d no-op -> hi=%h lo=%h", tag, op, HI, LO);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0] rop;
      Reset = 1'b0; Start = 1'b0; MDUop = 3'd0; A = '0; B = '0;
      tick();
      tick();
      chk("reset_busy", 64'(Busy), 64'd0);
      chk("reset_done", 64'(Done), 64'd0);
      chk("reset_hilo", {HI, LO}, 64'd0);
      Reset = 1'b1;

      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1, -1);
      chk("multu_max_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
      do_op(3'd1, -32'sd3, 32'd7, "mult_neg", -1, -1);
      chk("mult_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(3'd3, -32'sd7, 32'd2, "div_neg", -1, -1);
      chk("div_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(3'd4, 32'd100, 32'd0, "divu_zero", -1, -1);
      chk("divu_zero_const", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1, -1);
      chk("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
      tick();
      chk("done_single_pulse", 64'(Done), 64'd0);

      do_mt(3'd5, 32'h1234, "mthi");
      do_mt(3'd6, 32'h5678, "mtlo");
      chk("mt_const", {HI, LO}, 64'h0000_1234_0000_5678);

      do_op(3'd4, 32'd10, 32'd3, "divu_poke", 5, -1);
      chk("divu_poke_const", {HI, LO}, 64'h0000_0001_0000_0003);
      tick();
      chk("poke_not_queued", 64'(Busy), 64'd0);

      do_op(3'd2, 32'hDEAD_BEEF, 32'h1234_5678, "multu_rst", -1, 10);
      do_op(3'd4, 32'd9, 32'd2, "divu_after_rst", -1, -1);
      chk("divu_after_rst_const", {HI, LO}, 64'h0000_0001_0000_0004);

      do_nop(3'd0, "nop0");
      do_nop(3'd7, "nop7");

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         if (rop >= 3'd1 && rop <= 3'd4) do_op(rop, pick(), pick(), "rand", -1, -1);
         else if (rop == 3'd5 || rop == 3'd6) do_mt(rop, $urandom, "rand_mt");
         else do_nop(rop, "rand_nop");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
